// File: rtl/controle_multiciclo.sv
// controle_multiciclo: Moore control FSM for the multicycle MIPS datapath with
// memory-ready stretching and a retired-instruction counter.
module controle_multiciclo #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTEXE, RTWB, BEQ, ADDIEX, ADDIWB, JMP
  } state_t;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04,
                         OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  state_t st, nx;
  logic legal, retire;
  // zero is consumed by the datapath's PCWriteCond gate, not by the sequencer
  logic unused_zero;
  assign unused_zero = zero;
  assign state = st;
  assign legal = opcode inside {OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
  assign retire = st inside {MEMWB, RTWB, ADDIWB, BEQ, JMP} || (st == MEMWR && mem_ready);
  always_comb begin
    nx = FETCH;
    case (st)
      FETCH:  nx = mem_ready ? DECODE : FETCH;
      DECODE: nx = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                   opcode == OP_R    ? RTEXE  :
                   opcode == OP_BEQ  ? BEQ    :
                   opcode == OP_ADDI ? ADDIEX :
                   opcode == OP_J    ? JMP    : FETCH;
      MEMADR: nx = opcode == OP_LW ? MEMRD : MEMWR;
      MEMRD:  nx = mem_ready ? MEMWB : MEMRD;
      MEMWR:  nx = mem_ready ? FETCH : MEMWR;
      RTEXE:  nx = RTWB;
      ADDIEX: nx = ADDIWB;
      default: nx = FETCH;
    endcase
  end
  // outputs are forced low while reset is held so no strobe survives rst falling
  always_comb begin
    {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA} = '0;
    ALUSrcB = 2'b00;
    ALUOp = 2'b00;
    PCSrc = 2'b00;
    illegal = 1'b0;
    if (rst)
      case (st)
        FETCH:  begin MemRead = 1'b1; ALUSrcB = 2'b01; IRWrite = mem_ready; PCWrite = mem_ready; end
        DECODE: begin ALUSrcB = 2'b11; illegal = !legal; end
        MEMADR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
        MEMRD:  begin MemRead = 1'b1; IorD = 1'b1; end
        MEMWB:  begin RegWrite = 1'b1; MemtoReg = 1'b1; end
        MEMWR:  begin MemWrite = 1'b1; IorD = 1'b1; end
        RTEXE:  begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
        RTWB:   begin RegWrite = 1'b1; RegDst = 1'b1; end
        BEQ:    begin ALUSrcA = 1'b1; ALUOp = 2'b01; PCWriteCond = 1'b1; PCSrc = 2'b01; end
        ADDIEX: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
        ADDIWB: RegWrite = 1'b1;
        JMP:    begin PCWrite = 1'b1; PCSrc = 2'b10; end
        default: ;
      endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= FETCH;
      instr_count <= '0;
    end else begin
      st <= nx;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
- Moore FSM control unit for the multicycle MIPS processor, the successor to the single-cycle core.
- Sequences the shared-memory datapath through fetch, decode, execute, memory and write-back steps per instruction: PC, IR, register file, ALU and one unified memory.
- Stretches memory steps while the memory port is not ready, and counts retired instructions for the simulation benches.

Parameters:
CNT_W, 32, width of retired-instruction counter instr_count.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low (0 = reset)
opcode  input  6  instruction bits [31:26] from IR
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if zero=1 (beq)
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  IR load
MemtoReg  output  1  write-back data select: 0 = ALUOut, 1 = MDR
RegDst  output  1  destination select: 0 = rt, 1 = rd
RegWrite  output  1  register file write enable
ALUSrcA  output  1  ALU A select: 0 = PC, 1 = A
ALUSrcB  output  2  ALU B select: 00 = B, 01 = 4, 10 = signext imm, 11 = signext imm<<2
ALUOp  output  2  00 = add, 01 = sub, 10 = funct-decoded
PCSrc  output  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
state  output  4  current state code, debug only
instr_count  output  CNT_W  retired instructions
illegal  output  1  one-cycle pulse in DECODE on an unsupported opcode

Behaviour:
- Reset:
  - rst=0 forces state=FETCH (0) and instr_count=0 asynchronously.
  - While rst=0, every control output and illegal is 0.
- State codes:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5.
  - RTEXE=6, RTWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JMP=11.
- Outputs:
  - Decoded purely from state, except the mem_ready qualification in FETCH.
  - Any signal not listed for a state is 0.
- FETCH:
  - Always drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - Transitions by opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR.
    - 000000 -> RTEXE.
    - 000100 -> BEQ.
    - 001000 -> ADDIEX.
    - 000010 -> JMP.
    - Any other opcode -> FETCH with illegal=1; not retired.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD for lw, MEMWR for sw (opcode is stable from IR).
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready=1, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready=1, then FETCH.
- RTEXE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to RTWB.
- RTWB: RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSrc=01. Goes to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Goes to FETCH.
- JMP: PCWrite=1, PCSrc=10. Goes to FETCH.
- Latency in cycles, with mem_ready tied 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each wait cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Retirement:
  - instr_count increments by 1 on the clock edge leaving MEMWB, RTWB, ADDIWB, BEQ, JMP, or MEMWR with mem_ready=1.
  - Wraps modulo 2^CNT_W.
- Unreachable state codes 12-15 go to FETCH on the next edge, with all outputs 0.
- Reset asserted mid-instruction: the instruction is abandoned immediately. Partial writes are not retried, and no write strobe appears after rst falls.

Test Plan:
- Reset mid-MEMWR: assert rst=0 during MEMWR -> state=0, MemWrite=0 in the same cycle, instr_count=0; after release, FETCH resumes.
- Basic sequence, mem_ready=1: IR sequence addi, R-type add, lw, sw, beq (zero=1), j -> states 0,1,9,10 / 0,1,6,7 / 0,1,2,3,4 / 0,1,2,5 / 0,1,8 / 0,1,11. instr_count=6 after 23 cycles; PCWriteCond=1 only in BEQ.
- Memory wait: lw with mem_ready=0 for 3 cycles in FETCH and 2 in MEMRD -> lw takes 10 cycles. IRWrite and PCWrite pulse exactly once; RegWrite pulses exactly once with MemtoReg=1.
- Illegal opcode: opcode=111111 -> illegal=1 for exactly one cycle in DECODE, next state FETCH, instr_count unchanged, RegWrite/MemWrite never 1.
- Counter wrap: CNT_W=4, 17 j instructions -> instr_count reads 1.
